// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Shared definitions for the sprite mover. Holds the FSM state
//               encoding, the bit positions of the direction inputs and the
//               named pixel colours.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_WAIT  = 2'd1,
        S_ERASE = 2'd2,
        S_DRAW  = 2'd3
    } state_t;

    // Bit positions within the 4-bit dir input
    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;

    // 3-bit RGB colours
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;

endpackage
`default_nettype wire

// File: rtl/tick_timer.sv
`default_nettype none
// ============================================================================
// Module      : tick_timer
// Description : Free-running movement timer. Counts cycles while run is high
//               and emits a one-cycle tick on the last count of each period,
//               wrapping to zero. The count is frozen while run is low.
// Ports       : clk   - system clock
//               reset - asynchronous active-high reset
//               run   - count enable
//               tick  - one-cycle pulse every TICK_CYCLES running cycles
// Revision    : 1.0 - initial release
// ============================================================================
module tick_timer #(
    parameter int TICK_CYCLES = 524288
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap = run && (r_cnt == C_LAST);
    assign tick   = w_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_wrap) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= r_cnt + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// Module      : sprite_mover
// Description : Sprite datapath and FSM for the VGA game. Draws an
//               SPR_W x SPR_H sprite, and on each movement tick samples the
//               direction keys, clamps the new position to the screen, erases
//               the old sprite and redraws it, one pixel per cycle.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               enable            - lets the movement timer run
//               dir[3:0]          - up/down/left/right keys
//               x_out/y_out       - pixel coordinate to VGA adapter
//               color_out, plot   - pixel colour and write strobe
//               pos_x/pos_y       - current sprite top-left corner
//               busy              - high while drawing or erasing
//               tick              - movement tick pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int                 X_W         = 8,
    parameter int                 Y_W         = 7,
    parameter int                 SCREEN_W    = 160,
    parameter int                 SCREEN_H    = 120,
    parameter int                 SPR_W       = 4,
    parameter int                 SPR_H       = 4,
    parameter int                 STEP        = 1,
    parameter int                 TICK_CYCLES = 524288,
    parameter int                 COLOR_W     = 3,
    parameter logic [COLOR_W-1:0] SPR_COLOR   = RED,
    parameter logic [COLOR_W-1:0] BG_COLOR    = BLACK,
    parameter int                 INIT_X      = 80,
    parameter int                 INIT_Y      = 100
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [3:0]         dir,
    output logic [X_W-1:0]     x_out,
    output logic [Y_W-1:0]     y_out,
    output logic [COLOR_W-1:0] color_out,
    output logic               plot,
    output logic [X_W-1:0]     pos_x,
    output logic [Y_W-1:0]     pos_y,
    output logic               busy,
    output logic               tick
);

    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    // One bit wider than the coordinate so that pos+STEP never wraps
    localparam logic [X_W:0]   C_STEP_X  = XW1'(STEP);
    localparam logic [Y_W:0]   C_STEP_Y  = YW1'(STEP);
    localparam logic [X_W:0]   C_MAX_X   = XW1'(SCREEN_W - SPR_W);
    localparam logic [Y_W:0]   C_MAX_Y   = YW1'(SCREEN_H - SPR_H);
    localparam logic [X_W-1:0] C_INIT_X  = X_W'(INIT_X);
    localparam logic [Y_W-1:0] C_INIT_Y  = Y_W'(INIT_Y);
    localparam logic [X_W-1:0] C_LAST_OX = X_W'(SPR_W - 1);
    localparam logic [Y_W-1:0] C_LAST_OY = Y_W'(SPR_H - 1);
    localparam logic [X_W-1:0] C_ONE_X   = X_W'(1);
    localparam logic [Y_W-1:0] C_ONE_Y   = Y_W'(1);

    state_t         r_state;
    logic [X_W-1:0] r_pos_x;
    logic [Y_W-1:0] r_pos_y;
    logic [X_W-1:0] r_pend_x;
    logic [Y_W-1:0] r_pend_y;
    logic [X_W-1:0] r_ox;
    logic [Y_W-1:0] r_oy;

    logic           w_run;
    logic           w_tick;
    logic [X_W:0]   w_sum_x;
    logic [Y_W:0]   w_sum_y;
    logic [X_W-1:0] w_cand_x;
    logic [Y_W-1:0] w_cand_y;
    logic           w_move;
    logic           w_last_col;
    logic           w_last_px;

    // The timer only advances while idle, so redraw time never eats into
    // the movement period.
    assign w_run = enable && (r_state == S_WAIT);

    tick_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick_timer (
        .clk   (clk),
        .reset (reset),
        .run   (w_run),
        .tick  (w_tick)
    );

    // Candidate position; an axis with both or neither key pressed stays put
    always_comb begin
        w_sum_x  = {1'b0, r_pos_x} + C_STEP_X;
        w_sum_y  = {1'b0, r_pos_y} + C_STEP_Y;
        w_cand_x = r_pos_x;
        w_cand_y = r_pos_y;
        if (dir[DIR_RIGHT] && !dir[DIR_LEFT]) begin
            w_cand_x = (w_sum_x > C_MAX_X) ? C_MAX_X[X_W-1:0] : w_sum_x[X_W-1:0];
        end else if (dir[DIR_LEFT] && !dir[DIR_RIGHT]) begin
            w_cand_x = ({1'b0, r_pos_x} < C_STEP_X) ? '0 : (r_pos_x - C_STEP_X[X_W-1:0]);
        end
        if (dir[DIR_DOWN] && !dir[DIR_UP]) begin
            w_cand_y = (w_sum_y > C_MAX_Y) ? C_MAX_Y[Y_W-1:0] : w_sum_y[Y_W-1:0];
        end else if (dir[DIR_UP] && !dir[DIR_DOWN]) begin
            w_cand_y = ({1'b0, r_pos_y} < C_STEP_Y) ? '0 : (r_pos_y - C_STEP_Y[Y_W-1:0]);
        end
    end

    assign w_move     = (w_cand_x != r_pos_x) || (w_cand_y != r_pos_y);
    assign w_last_col = (r_ox == C_LAST_OX);
    assign w_last_px  = w_last_col && (r_oy == C_LAST_OY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_INIT;
            r_pos_x  <= C_INIT_X;
            r_pos_y  <= C_INIT_Y;
            r_pend_x <= C_INIT_X;
            r_pend_y <= C_INIT_Y;
            r_ox     <= '0;
            r_oy     <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_ox    <= '0;
                    r_oy    <= '0;
                    r_state <= S_DRAW;
                end
                S_WAIT: begin
                    if (w_tick && w_move) begin
                        r_pend_x <= w_cand_x;
                        r_pend_y <= w_cand_y;
                        r_state  <= S_ERASE;
                    end
                end
                S_ERASE, S_DRAW: begin
                    if (w_last_px) begin
                        r_ox <= '0;
                        r_oy <= '0;
                        if (r_state == S_ERASE) begin
                            r_pos_x <= r_pend_x;
                            r_pos_y <= r_pend_y;
                            r_state <= S_DRAW;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end else if (w_last_col) begin
                        r_ox <= '0;
                        r_oy <= r_oy + C_ONE_Y;
                    end else begin
                        r_ox <= r_ox + C_ONE_X;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    // Outputs decode directly from registered state, so an asynchronous
    // reset drops plot in the same instant.
    assign x_out     = r_pos_x + r_ox;
    assign y_out     = r_pos_y + r_oy;
    assign plot      = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign busy      = (r_state != S_WAIT);
    assign color_out = (r_state == S_DRAW) ? SPR_COLOR : BG_COLOR;
    assign pos_x     = r_pos_x;
    assign pos_y     = r_pos_y;
    assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_mover
// Description : Self-checking bench for sprite_mover. Three instances with
//               different start positions / step sizes share one clock and
//               reset; a position model per instance predicts every pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_mover;

    localparam int TICK = 8;
    localparam int SW   = 4;
    localparam int SH   = 4;
    localparam int MAXX = 160 - SW;
    localparam int MAXY = 120 - SH;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en [3];
    logic [3:0] dr [3];
    logic [7:0] xo [3];
    logic [6:0] yo [3];
    logic [2:0] co [3];
    logic       pl [3];
    logic [7:0] px [3];
    logic [6:0] py [3];
    logic       bz [3];
    logic       tk [3];

    int checks = 0;
    int errors = 0;
    int sel    = 0;

    int m_px [3];
    int m_py [3];
    int m_rem [3];
    int c_ix [3];
    int c_iy [3];
    int c_step [3];

    always #5 clk = ~clk;

    sprite_mover #(.TICK_CYCLES(TICK), .INIT_X(80), .INIT_Y(100), .STEP(1)) u_dut0 (
        .clk(clk), .reset(reset), .enable(en[0]), .dir(dr[0]),
        .x_out(xo[0]), .y_out(yo[0]), .color_out(co[0]), .plot(pl[0]),
        .pos_x(px[0]), .pos_y(py[0]), .busy(bz[0]), .tick(tk[0]));

    sprite_mover #(.TICK_CYCLES(TICK), .INIT_X(156), .INIT_Y(116), .STEP(1)) u_dut1 (
        .clk(clk), .reset(reset), .enable(en[1]), .dir(dr[1]),
        .x_out(xo[1]), .y_out(yo[1]), .color_out(co[1]), .plot(pl[1]),
        .pos_x(px[1]), .pos_y(py[1]), .busy(bz[1]), .tick(tk[1]));

    sprite_mover #(.TICK_CYCLES(TICK), .INIT_X(1), .INIT_Y(100), .STEP(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(en[2]), .dir(dr[2]),
        .x_out(xo[2]), .y_out(yo[2]), .color_out(co[2]), .plot(pl[2]),
        .pos_x(px[2]), .pos_y(py[2]), .busy(bz[2]), .tick(tk[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
            $error("check %s", tag);
        end
    endtask

    // Move one axis by step, saturating at 0 and maxp; no move unless exactly one key
    function automatic int mv(int p, int step, int maxp, logic inc, logic dec);
        if (inc && !dec) return (p + step > maxp) ? maxp : p + step;
        if (dec && !inc) return (p < step) ? 0 : p - step;
        return p;
    endfunction

    task automatic chk_idle(input string tag, input logic exp_tick);
        chk({tag, "_plot"}, 32'(pl[sel]), 0);
        chk({tag, "_busy"}, 32'(bz[sel]), 0);
        chk({tag, "_tick"}, 32'(tk[sel]), 32'(exp_tick));
    endtask

    // SW*SH plotted pixels in row-major order; dir is scrambled to show it is ignored
    task automatic chk_frame(input logic [2:0] col, input int bx, input int by);
        for (int oy = 0; oy < SH; oy++) begin
            for (int ox = 0; ox < SW; ox++) begin
                @(negedge clk);
                dr[sel] = 4'($urandom_range(0, 15));
                #1;
                chk("frame_plot",  32'(pl[sel]), 1);
                chk("frame_busy",  32'(bz[sel]), 1);
                chk("frame_color", 32'(co[sel]), 32'(col));
                chk("frame_x",     32'(xo[sel]), bx + ox);
                chk("frame_y",     32'(yo[sel]), by + oy);
                chk("frame_posx",  32'(px[sel]), bx);
                chk("frame_posy",  32'(py[sel]), by);
            end
        end
    endtask

    // Release reset at a falling edge and check INIT then the first draw
    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_px[i]  = c_ix[i];
            m_py[i]  = c_iy[i];
            m_rem[i] = TICK;
        end
        #1;
        chk("init_plot",  32'(pl[sel]), 0);
        chk("init_busy",  32'(bz[sel]), 1);
        chk("init_tick",  32'(tk[sel]), 0);
        chk("init_color", 32'(co[sel]), 0);
        chk("init_x",     32'(xo[sel]), m_px[sel]);
        chk("init_y",     32'(yo[sel]), m_py[sel]);
        chk_frame(3'b100, m_px[sel], m_py[sel]);
        @(negedge clk);
        en[sel] = 1'b0;
        #1;
        chk_idle("after_init", 1'b0);
    endtask

    // Run a enabled cycles, gap disabled cycles, then enabled until the tick
    task automatic tick_and_move(input logic [3:0] d, input int a, input int gap);
        int nx, ny, aa;
        aa = (a > m_rem[sel] - 1) ? m_rem[sel] - 1 : a;
        dr[sel] = d;
        for (int i = 0; i < aa; i++) begin
            @(negedge clk); en[sel] = 1'b1; #1;
            chk_idle("count", 1'b0);
        end
        m_rem[sel] -= aa;
        for (int i = 0; i < gap; i++) begin
            @(negedge clk); en[sel] = 1'b0; #1;
            chk_idle("frozen", 1'b0);
        end
        for (int i = 0; i < m_rem[sel]; i++) begin
            @(negedge clk); en[sel] = 1'b1; #1;
            chk_idle("wait_tick", 1'(i == m_rem[sel] - 1));
        end
        m_rem[sel] = TICK;
        nx = mv(m_px[sel], c_step[sel], MAXX, d[0], d[1]);
        ny = mv(m_py[sel], c_step[sel], MAXY, d[2], d[3]);
        if (nx != m_px[sel] || ny != m_py[sel]) begin
            chk_frame(3'b000, m_px[sel], m_py[sel]);
            m_px[sel] = nx;
            m_py[sel] = ny;
            chk_frame(3'b100, nx, ny);
        end
        @(negedge clk); en[sel] = 1'b0; #1;
        chk_idle("after_move", 1'b0);
        chk("pos_x", 32'(px[sel]), m_px[sel]);
        chk("pos_y", 32'(py[sel]), m_py[sel]);
    endtask

    initial begin
        c_ix = '{80, 156, 1};
        c_iy = '{100, 116, 100};
        c_step = '{1, 1, 2};
        for (int i = 0; i < 3; i++) begin
            en[i] = 1'b0;
            dr[i] = 4'b0000;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_plot", 32'(pl[0]), 0);
        chk("rst_busy", 32'(bz[0]), 1);
        chk("rst_posx", 32'(px[0]), 80);
        release_reset();

        // Instance 0: basic right move, long disable gap, then random walk
        sel = 0;
        tick_and_move(4'b0001, 0, 0);
        tick_and_move(4'b0100, 3, 100);
        for (int k = 0; k < 12; k++) begin
            tick_and_move(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 5));
        end

        // Instance 1: parked in the bottom-right corner
        sel = 1;
        tick_and_move(4'b0001, 0, 0);
        tick_and_move(4'b0100, 2, 1);
        tick_and_move(4'b0101, 0, 0);
        tick_and_move(4'b1111, 0, 0);
        tick_and_move(4'b0010, 0, 0);
        for (int k = 0; k < 4; k++) begin
            tick_and_move(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 3));
        end

        // Instance 2: step of 2 clamped against the left wall
        sel = 2;
        tick_and_move(4'b1010, 0, 0);
        tick_and_move(4'b0011, 0, 0);
        tick_and_move(4'b0010, 1, 2);
        for (int k = 0; k < 6; k++) begin
            tick_and_move(4'($urandom_range(0, 15)), $urandom_range(0, 7), $urandom_range(0, 3));
        end

        // Instance 0: reset on the 5th erase pixel aborts the move
        sel = 0;
        dr[0] = (m_px[0] < MAXX) ? 4'b0001 : 4'b0010;
        for (int i = 0; i < m_rem[0]; i++) begin
            @(negedge clk); en[0] = 1'b1; #1;
            chk_idle("abort_wait", 1'(i == m_rem[0] - 1));
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("abort_erase_plot",  32'(pl[0]), 1);
            chk("abort_erase_color", 32'(co[0]), 0);
        end
        reset = 1'b1;
        #1;
        chk("abort_plot", 32'(pl[0]), 0);
        chk("abort_busy", 32'(bz[0]), 1);
        chk("abort_posx", 32'(px[0]), 80);
        chk("abort_posy", 32'(py[0]), 100);
        chk("abort_x",    32'(xo[0]), 80);
        chk("abort_y",    32'(yo[0]), 100);
        en[0] = 1'b0;
        release_reset();
        tick_and_move(4'b1000, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
Parametrised sprite datapath and FSM for the VGA game. Draws an SPR_W x SPR_H sprite at a start position. On each movement tick it samples the direction inputs, clamps the new position to the screen, erases the old sprite and redraws it at the new position. It emits one pixel per cycle to the VGA adapter (x_out/y_out/color_out/plot), replacing the fixed-position, single-pixel drawing of the previous datapath.

Parameters:
X_W, 8, width of x coordinate
Y_W, 7, width of y coordinate
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
SPR_W, 4, sprite width (>=1, <=SCREEN_W)
SPR_H, 4, sprite height (>=1, <=SCREEN_H)
STEP, 1, pixels moved per tick (>=1)
TICK_CYCLES, 524288, clk cycles between movement ticks (>=2)
COLOR_W, 3, colour width
SPR_COLOR, 3'b100, sprite colour (red)
BG_COLOR, 3'b000, erase colour (black)
INIT_X, 80, start x (<=SCREEN_W-SPR_W)
INIT_Y, 100, start y (<=SCREEN_H-SPR_H)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  tick timer runs only while high
dir  in  4  [0]=right [1]=left [2]=down [3]=up
x_out  out  X_W  pixel x to VGA adapter
y_out  out  Y_W  pixel y to VGA adapter
color_out  out  COLOR_W  pixel colour
plot  out  1  write strobe, one pixel per high cycle
pos_x  out  X_W  current sprite top-left x
pos_y  out  Y_W  current sprite top-left y
busy  out  1  high while INIT/ERASE/DRAW in progress
tick  out  1  one-cycle pulse at movement tick

Behaviour:
- States: S_INIT, S_WAIT, S_ERASE, S_DRAW.
- Reset (async) values: state=S_INIT, pos=(INIT_X,INIT_Y), pending pos=(INIT_X,INIT_Y), offsets ox=oy=0, timer=0. Outputs: plot=0, busy=1, tick=0, x_out=INIT_X, y_out=INIT_Y, color_out=BG_COLOR.
- Reset asserted mid-operation aborts immediately. A partial sprite left on screen is accepted; higher-level logic clears the screen.
- S_INIT: one cycle, plot=0, then -> S_DRAW.
- ERASE and DRAW:
  - Scan offsets row-major: ox advances 0..SPR_W-1 each cycle; at ox=SPR_W-1, ox->0 and oy increments.
  - Exactly SPR_W*SPR_H cycles with plot=1.
  - x_out=pos_x+ox, y_out=pos_y+oy, combinational from registers.
  - color_out=BG_COLOR in ERASE, SPR_COLOR in DRAW.
- Last ERASE pixel (ox=SPR_W-1, oy=SPR_H-1): next cycle pos<=pending, offsets<=0, -> S_DRAW.
- Last DRAW pixel: -> S_WAIT, offsets<=0.
- S_WAIT:
  - plot=0, busy=0.
  - If enable: timer increments. At timer==TICK_CYCLES-1, tick=1 that cycle and timer<=0.
  - If !enable: timer holds.
  - Timer holds in all other states.
- At tick, compute the candidate position from dir:
  - x: right-only -> min(pos_x+STEP, SCREEN_W-SPR_W). Left-only -> (pos_x<STEP ? 0 : pos_x-STEP).
  - y: down-only -> min(pos_y+STEP, SCREEN_H-SPR_H). Up-only -> (pos_y<STEP ? 0 : pos_y-STEP).
  - Both or neither bits of an axis: that axis unchanged.
  - Sum computed one bit wider than X_W/Y_W; no wrap-around.
- If candidate == pos (no key, opposing keys, or at a wall): stay in S_WAIT, no plot.
- Otherwise pending<=candidate, -> S_ERASE.
- dir is sampled only on the tick cycle. Changes during ERASE/DRAW are ignored.
- Latency from tick to first DRAW pixel is SPR_W*SPR_H+1 cycles. Redraw period is 2*SPR_W*SPR_H cycles; it must be less than TICK_CYCLES by construction.

Decomposition:
- Package sprite_pkg: state encoding, DIR_RIGHT/LEFT/DOWN/UP bit indices, colour constants BLACK/RED/GREEN.
- One sub-module, tick_timer: parametrised TICK_CYCLES, inputs clk/reset/run, outputs tick, counter width $clog2(TICK_CYCLES).
- Offset scanner and clamp logic stay in sprite_mover.

Test Plan:
- Reset then release (defaults): 1 cycle plot=0. Then 16 cycles plot=1, color=100, (x,y) = (80,100),(81,100)…(83,103). Then busy=0.
- TICK_CYCLES=8, enable=1, dir=0001: tick after 8 WAIT cycles. 16 erase pixels color 000 at x80-83, then 16 draw pixels color 100 at x81-84. pos_x=81.
- INIT_X=156, dir=0001, tick: no plot, pos_x stays 156, busy stays 0.
- INIT_X=1, STEP=2, dir=0010|1000 (left+up), tick: pos -> (0,98), full erase/draw. dir=0011: x unchanged, no redraw.
- enable=0 for 100 cycles in S_WAIT: no tick, timer frozen. Re-enable: tick after the remaining count.
- Assert reset at 5th ERASE pixel: plot drops to 0 asynchronously, pos=(80,100). After release: S_INIT, then full redraw at (80,100).
